// File: rtl/dma_pkg.sv
// Shared definitions for the overlay DMA receive path.
//   DMA_DATA_W      : stream data width (128)
//   DMA_KEEP_W      : byte-enable width matching DMA_DATA_W
//   dma_hdr_t       : 128-bit length-prefix header; beat count sits in the LSBs
//   framer_state_e  : egress FSM state encoding of dma_packet_framer
//   make_hdr()      : builds a header from a total beat count
package dma_pkg;

    localparam int DMA_DATA_W = 128;
    localparam int DMA_KEEP_W = DMA_DATA_W / 8;

    typedef struct packed {
        logic [DMA_DATA_W-33:0] rsvd;
        logic [31:0]            count;
    } dma_hdr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } framer_state_e;

    function automatic dma_hdr_t make_hdr(input logic [31:0] beats);
        dma_hdr_t h;
        h.rsvd  = '0;
        h.count = beats;
        return h;
    endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// rd_data always shows the oldest entry while !empty; rd_en consumes it.
// Same-cycle push and pop are supported and keep the occupancy exact.
// Writes while full and reads while empty are ignored.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-low reset (empties the FIFO)
//   wr_en    in   push request
//   wr_data  in   WIDTH  data to push
//   rd_en    in   pop request
//   rd_data  out  WIDTH  head of the FIFO
//   full     out  registered full flag
//   empty    out  registered empty flag
// DEPTH must be a power of two and at least 2 (pointers wrap naturally).
module dma_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push, pop;

    assign push = wr_en && !full_q;
    assign pop  = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        // Flags come from the next occupancy so they are valid straight out of a flop.
        full_d  = (count_d == DEPTH_L);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/dma_packet_framer.sv
// Receive-side framer for the overlay DMA path (MM2S AXI-stream -> overlay).
// Each tlast-delimited packet is stored completely, then emitted as one header
// beat holding the total beat count (payload + 1) followed by the payload beats.
// Packets reaching MAX_PKT_BEATS without tlast are cut there (trunc_err pulse)
// and the following beats form a new packet.
// Optional feature macro: DMA_FRAMER_PKTCNT_EN adds the pkt_count port/counter.
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-low reset, synchronous release
//   s_tdata    in   128  ingress data
//   s_tvalid   in   ingress valid
//   s_tready   out  ingress ready
//   s_tlast    in   last payload beat of the packet
//   dout       out  128  egress data (header or payload)
//   valid      out  egress valid
//   ready      in   egress ready
//   trunc_err  out  one-cycle pulse after a forced end of packet
//   pkt_count  out  32   packets fully emitted (DMA_FRAMER_PKTCNT_EN only)
//
// Egress FSM
//   state | meaning
//   IDLE  | no packet in flight; pops a length and loads the header when one is queued
//   HDR   | header on dout, waiting for ready
//   PAY   | payload beat on dout; rem_q beats of this packet still to hand off
module dma_packet_framer
    import dma_pkg::*;
#(
    parameter int DEPTH         = 512,
    parameter int LEN_DEPTH     = 16,
    parameter int MAX_PKT_BEATS = DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DMA_DATA_W-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DMA_DATA_W-1:0] dout,
    output logic                  valid,
    input  logic                  ready,
    output logic                  trunc_err
`ifdef DMA_FRAMER_PKTCNT_EN
    ,
    output logic [31:0]           pkt_count
`endif
);

    localparam int LEN_W = $clog2(MAX_PKT_BEATS + 2);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] MAX_BEATS = LEN_W'(MAX_PKT_BEATS);

    // Ingress
    logic                  run_q;
    logic                  in_beat;
    logic                  at_max;
    logic [LEN_W-1:0]      in_cnt_q, in_cnt_d;
    logic                  trunc_q, trunc_d;

    // FIFO handshakes
    logic                  data_pop;
    logic [DMA_DATA_W-1:0] data_rd;
    logic                  data_full, data_empty;
    logic                  len_push, len_pop;
    logic [LEN_W-1:0]      len_wr, len_rd;
    logic                  len_full, len_empty;

    // Egress
    framer_state_e         state_q, state_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [DMA_DATA_W-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  last_hs;

    // run_q keeps s_tready low during reset and for the first cycle after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign s_tready = run_q && !data_full && !len_full;
    assign in_beat  = s_tvalid && s_tready;
    assign at_max   = ((in_cnt_q + LEN_ONE) == MAX_BEATS);

    always_comb begin
        in_cnt_d = in_cnt_q;
        len_push = 1'b0;
        len_wr   = in_cnt_q + LEN_ONE;
        trunc_d  = 1'b0;
        if (in_beat) begin
            if (s_tlast || at_max) begin
                len_push = 1'b1;
                in_cnt_d = '0;
                trunc_d  = !s_tlast;
            end else begin
                in_cnt_d = in_cnt_q + LEN_ONE;
            end
        end
    end

    dma_sync_fifo #(
        .WIDTH (DMA_DATA_W),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_beat),
        .wr_data (s_tdata),
        .rd_en   (data_pop),
        .rd_data (data_rd),
        .full    (data_full),
        .empty   (data_empty)
    );

    dma_sync_fifo #(
        .WIDTH (LEN_W),
        .DEPTH (LEN_DEPTH)
    ) u_len_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (len_push),
        .wr_data (len_wr),
        .rd_en   (len_pop),
        .rd_data (len_rd),
        .full    (len_full),
        .empty   (len_empty)
    );

    // A length is only queued once all its payload is in the data FIFO, so the
    // data_empty gating below never actually blocks a pop in normal operation.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        len_pop  = 1'b0;
        data_pop = 1'b0;
        last_hs  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!len_empty) begin
                    len_pop = 1'b1;
                    rem_d   = len_rd;
                    dout_d  = make_hdr(32'(len_rd) + 32'd1);
                    valid_d = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (ready) begin
                    data_pop = !data_empty;
                    dout_d   = data_rd;
                    state_d  = PAY;
                end
            end
            PAY: begin
                if (ready) begin
                    rem_d = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        last_hs = 1'b1;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        data_pop = !data_empty;
                        dout_d   = data_rd;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_cnt_q <= '0;
            trunc_q  <= 1'b0;
            state_q  <= IDLE;
            rem_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            in_cnt_q <= in_cnt_d;
            trunc_q  <= trunc_d;
            state_q  <= state_d;
            rem_q    <= rem_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign trunc_err = trunc_q;

`ifdef DMA_FRAMER_PKTCNT_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (last_hs) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_count = pkt_cnt_q;
`else
    logic unused_last_hs;
    assign unused_last_hs = last_hs;
`endif

endmodule

// File: tb/tb_dma_packet_framer.sv
module tb_dma_packet_framer;

    localparam int DEPTH     = 16;
    localparam int LEN_DEPTH = 4;
    localparam int MAX_BEATS = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         s_tlast = 1'b0;
    logic [127:0] dout;
    logic         valid;
    logic         ready = 1'b0;
    logic         trunc_err;
`ifdef DMA_FRAMER_PKTCNT_EN
    logic [31:0]  pkt_count;
`endif

    dma_packet_framer #(
        .DEPTH         (DEPTH),
        .LEN_DEPTH     (LEN_DEPTH),
        .MAX_PKT_BEATS (MAX_BEATS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .dout      (dout),
        .valid     (valid),
        .ready     (ready),
        .trunc_err (trunc_err)
`ifdef DMA_FRAMER_PKTCNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [127:0] mk(input int p, input int i);
        return {32'hC0DE0000 + 32'(p), 32'(i), ~32'(p), 32'(i) ^ 32'h5A5A5A5A};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [127:0] data;
        bit           last;
    } beat_t;

    beat_t        exp_q[$];
    logic [127:0] cur_q[$];
    logic [127:0] out_log[$];
    bit           trunc_exp = 0;
    int           trunc_seen = 0;
    bit           prev_stall = 0;
    bit           prev_valid = 0;
    logic [127:0] prev_dout = '0;
    bit           in_pkt = 0;
    int           last_in_cyc = 0;
    int           hdr_cyc = 0;
    logic [31:0]  pc_model = '0;

    always @(negedge clk) begin
        if (!reset) begin
            chk(valid == 1'b0, "rst_valid", 128'(valid), 128'd0);
            chk(s_tready == 1'b0, "rst_s_tready", 128'(s_tready), 128'd0);
            chk(trunc_err == 1'b0, "rst_trunc_err", 128'(trunc_err), 128'd0);
            chk(dout == '0, "rst_dout", dout, 128'd0);
`ifdef DMA_FRAMER_PKTCNT_EN
            chk(pkt_count == 32'd0, "rst_pkt_count", 128'(pkt_count), 128'd0);
`endif
            exp_q.delete();
            cur_q.delete();
            trunc_exp  = 0;
            prev_stall = 0;
            prev_valid = 0;
            in_pkt     = 0;
            pc_model   = '0;
        end else begin
            chk(trunc_err == trunc_exp, "trunc_err", 128'(trunc_err), 128'(trunc_exp));
            if (trunc_err) trunc_seen++;
`ifdef DMA_FRAMER_PKTCNT_EN
            chk(pkt_count == pc_model, "pkt_count", 128'(pkt_count), 128'(pc_model));
`endif
            if (prev_stall) chk(valid && dout == prev_dout, "hold_under_backpressure", dout, prev_dout);
            if (in_pkt) chk(valid == 1'b1, "gap_inside_packet", 128'(valid), 128'd1);
            if (valid && !prev_valid) hdr_cyc = cyc;
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_beat", dout, 128'd0);
                end else begin
                    chk(dout == exp_q[0].data, "dout", dout, exp_q[0].data);
                    if (ready) begin
                        out_log.push_back(dout);
                        in_pkt = !exp_q[0].last;
                        if (exp_q[0].last) pc_model = pc_model + 32'd1;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_valid = valid;
            prev_stall = valid && !ready;
            prev_dout  = dout;

            trunc_exp = 0;
            if (s_tvalid && s_tready) begin
                cur_q.push_back(s_tdata);
                if (s_tlast || cur_q.size() == MAX_BEATS) begin
                    if (s_tlast) last_in_cyc = cyc;
                    trunc_exp = !s_tlast;
                    exp_q.push_back('{128'(cur_q.size() + 1), 1'b0});
                    for (int i = 0; i < cur_q.size(); i++)
                        exp_q.push_back('{cur_q[i], (i == cur_q.size() - 1)});
                    cur_q.delete();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int ready_mode = 0;   // 0: always ready, 1: toggle each cycle, 2: held low

    always begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            default: ready = 1'b0;
        endcase
    end

    task automatic push_beat(input logic [127:0] d, input logic l);
        int g = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = l;
        @(negedge clk);
        while (!s_tready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk(1'b0, "ingress_timeout", 128'(s_tready), 128'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send(input int p, input int n);
        for (int i = 0; i < n; i++) push_beat(mk(p, i), (i == n - 1));
    endtask

    task automatic drain();
        int g = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || valid) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) chk(1'b0, "drain_timeout", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int tb_before;
        int g;
`ifdef DMA_FRAMER_PKTCNT_EN
        logic [31:0] pc_before;
`endif
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: 3-beat packet, ready=1
        out_log.delete();
        send(1, 3);
        drain();
        chk(out_log.size() == 4, "t1_beats", 128'(out_log.size()), 128'd4);
        chk(out_log[0] == 128'd4, "t1_header", out_log[0], 128'd4);
        for (int i = 0; i < 3; i++) chk(out_log[i+1] == mk(1, i), "t1_payload", out_log[i+1], mk(1, i));
        chk(hdr_cyc - last_in_cyc == 2, "t1_header_latency", 128'(hdr_cyc - last_in_cyc), 128'd2);

        // 2: 1-beat packet
        out_log.delete();
        send(2, 1);
        drain();
        chk(out_log.size() == 2, "t2_beats", 128'(out_log.size()), 128'd2);
        chk(out_log[0] == 128'd2, "t2_header", out_log[0], 128'd2);
        chk(out_log[1] == mk(2, 0), "t2_payload", out_log[1], mk(2, 0));

        // 3: packets of 2 and 5 back-to-back
        out_log.delete();
`ifdef DMA_FRAMER_PKTCNT_EN
        pc_before = pkt_count;
`endif
        send(3, 2);
        send(4, 5);
        drain();
        chk(out_log.size() == 9, "t3_beats", 128'(out_log.size()), 128'd9);
        chk(out_log[0] == 128'd3, "t3_header_a", out_log[0], 128'd3);
        chk(out_log[3] == 128'd6, "t3_header_b", out_log[3], 128'd6);
        for (int i = 0; i < 2; i++) chk(out_log[i+1] == mk(3, i), "t3_payload_a", out_log[i+1], mk(3, i));
        for (int i = 0; i < 5; i++) chk(out_log[i+4] == mk(4, i), "t3_payload_b", out_log[i+4], mk(4, i));
`ifdef DMA_FRAMER_PKTCNT_EN
        chk(pkt_count - pc_before == 32'd2, "t3_pkt_count_delta", 128'(pkt_count - pc_before), 128'd2);
`endif

        // 4: ready toggling during a 4-beat packet
        out_log.delete();
        ready_mode = 1;
        send(5, 4);
        drain();
        ready_mode = 0;
        chk(out_log.size() == 5, "t4_handoffs", 128'(out_log.size()), 128'd5);
        chk(out_log[0] == 128'd5, "t4_header", out_log[0], 128'd5);
        chk(out_log[4] == mk(5, 3), "t4_last_payload", out_log[4], mk(5, 3));

        // 5: 10 beats with MAX_PKT_BEATS=8 -> 8 + 2
        out_log.delete();
        tb_before = trunc_seen;
        send(6, 10);
        drain();
        chk(trunc_seen - tb_before == 1, "t5_trunc_pulses", 128'(trunc_seen - tb_before), 128'd1);
        chk(out_log.size() == 12, "t5_beats", 128'(out_log.size()), 128'd12);
        chk(out_log[0] == 128'd9, "t5_header_a", out_log[0], 128'd9);
        chk(out_log[9] == 128'd3, "t5_header_b", out_log[9], 128'd3);
        for (int i = 0; i < 8; i++) chk(out_log[i+1] == mk(6, i), "t5_payload_a", out_log[i+1], mk(6, i));
        chk(out_log[10] == mk(6, 8), "t5_payload_b0", out_log[10], mk(6, 8));
        chk(out_log[11] == mk(6, 9), "t5_payload_b1", out_log[11], mk(6, 9));

        // 6: reset mid-payload and mid-ingress
        ready_mode = 2;
        @(posedge clk);
        #1;
        send(7, 4);
        g = 0;
        @(negedge clk);
        while (!valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk(1'b0, "t6_header_timeout", 128'(valid), 128'd1);
        @(posedge clk);
        #1 ready_mode = 0;
        @(posedge clk);
        @(posedge clk);
        #1 ready_mode = 2;
        push_beat(mk(8, 0), 1'b0);
        push_beat(mk(8, 1), 1'b0);
        #2 reset = 1'b0;
        #1;
        chk(valid == 1'b0, "t6_valid_in_reset", 128'(valid), 128'd0);
        chk(s_tready == 1'b0, "t6_s_tready_in_reset", 128'(s_tready), 128'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        out_log.delete();
        ready_mode = 0;
        @(posedge clk);
        #1;
        send(9, 3);
        drain();
        chk(out_log.size() == 4, "t6_beats", 128'(out_log.size()), 128'd4);
        chk(out_log[0] == 128'd4, "t6_header", out_log[0], 128'd4);
        for (int i = 0; i < 3; i++) chk(out_log[i+1] == mk(9, i), "t6_payload", out_log[i+1], mk(9, i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
